// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter sequencer.
package pc_pkg;

  // Next-PC selection presented on the 2-bit mode input.
  typedef enum logic [1:0] {
    MODE_INC    = 2'b00,
    MODE_BRANCH = 2'b01,
    MODE_JUMP   = 2'b10,
    MODE_RET    = 2'b11
  } mode_e;

endpackage

// File: rtl/return_stack.sv
// Circular return-address stack. A push while full overwrites the oldest
// entry so the newest RAS_DEPTH addresses always remain in LIFO order.
module return_stack #(
  parameter int WIDTH     = 16,
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             push_overflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(RAS_DEPTH);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr;      // index of the current top entry
  logic [PTR_W-1:0] ptr_inc;
  logic [PTR_W-1:0] ptr_dec;
  logic [CNT_W-1:0] count;

  assign ptr_inc = (ptr == LAST_IDX) ? '0 : ptr + PTR_W'(1);
  assign ptr_dec = (ptr == '0) ? LAST_IDX : ptr - PTR_W'(1);

  assign empty         = (count == '0);
  assign full          = (count == DEPTH_CNT);
  assign push_overflow = push & full;
  assign top           = empty ? '0 : mem[ptr];

  // Pointer and occupancy; push wins if both are ever raised together.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr_inc;
      if (!full) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      ptr   <= ptr_dec;
      count <= count - CNT_W'(1);
    end
  end

  // Entry storage; when full, ptr_inc lands on the oldest entry.
  // NOTE: entries are deliberately not reset -- count gates visibility, and
  // leaving the array reset-free lets it map onto plain storage.
  always_ff @(posedge clk) begin
    if (push) mem[ptr_inc] <= din;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage PC register with increment, relative branch, absolute
// jump/call and return, backed by a circular return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int STEP      = 1,
  parameter int RAS_DEPTH = 4,
  parameter int RESET_PC  = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             cond,
  input  logic [WIDTH-1:0] offset,
  input  logic [WIDTH-1:0] target,
  input  logic             call,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] link_top,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_PC);

  logic [WIDTH-1:0] seq;
  logic [WIDTH-1:0] pc_next;
  logic             push_req;
  logic             pop_req;
  logic             underflow_req;
  logic             push;
  logic             pop;
  logic             push_overflow;

  assign seq = pc + STEP_W;  // carry discarded: wraps modulo 2^WIDTH

  // Next-PC mux and stack requests, before stall gating.
  // NOTE: every output gets a default first so no path leaves a value
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    pc_next       = seq;
    push_req      = 1'b0;
    pop_req       = 1'b0;
    underflow_req = 1'b0;
    case (mode_e'(mode))
      MODE_INC:    pc_next = seq;
      MODE_BRANCH: if (cond) pc_next = seq + offset;
      MODE_JUMP: begin
        pc_next  = target;
        push_req = call;
      end
      MODE_RET: begin
        if (!ras_empty) begin
          pc_next = link_top;
          pop_req = 1'b1;
        end else begin
          underflow_req = 1'b1;
        end
      end
      default: pc_next = seq;
    endcase
  end

  // A stall must leave the stack untouched regardless of mode or call.
  assign push = en & push_req;
  assign pop  = en & pop_req;

  return_stack #(
    .WIDTH    (WIDTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .din          (seq),
    .top          (link_top),
    .empty        (ras_empty),
    .full         (ras_full),
    .push_overflow(push_overflow)
  );

  // PC register: reset first, then advance only when enabled.
  always_ff @(posedge clk) begin
    if (reset)   pc <= RESET_W;
    else if (en) pc <= pc_next;
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_overflow)       overflow  <= 1'b1;
      if (en && underflow_req) underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each directed step queues the
// hand-computed post-edge state; a monitor pops and compares it.
module tb_pc_sequencer;
  import pc_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b1;
  logic [1:0]  mode = MODE_INC;
  logic        cond = 1'b0;
  logic [15:0] offset = '0;
  logic [15:0] target = '0;
  logic        call = 1'b0;
  logic [15:0] pc;
  logic [15:0] link_top;
  logic        ras_empty;
  logic        ras_full;
  logic        overflow;
  logic        underflow;

  typedef struct {
    string       name;
    logic [15:0] pc;
    logic [15:0] link;
    logic [3:0]  flags;  // {empty, full, overflow, underflow}
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  pc_sequencer #(
    .WIDTH(16), .STEP(1), .RAS_DEPTH(4), .RESET_PC(0)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .cond     (cond),
    .offset   (offset),
    .target   (target),
    .call     (call),
    .pc       (pc),
    .link_top (link_top),
    .ras_empty(ras_empty),
    .ras_full (ras_full),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input string field,
                       input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
    end
  endtask

  // Monitor: outputs are registered, so sample mid-cycle on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, "pc",    pc,       e.pc);
        check(e.name, "link",  link_top, e.link);
        check(e.name, "flags", {12'h0, ras_empty, ras_full, overflow, underflow},
              {12'h0, e.flags});
      end
    end
  end

  // Drive one cycle of inputs and queue the expected state after the edge.
  task automatic step(input string name, input logic r, input logic e,
                      input logic [1:0] m, input logic c, input logic [15:0] off,
                      input logic [15:0] tgt, input logic cl,
                      input logic [15:0] xpc, input logic [15:0] xlink,
                      input logic [3:0] xf);
    @(negedge clk);
    reset = r; en = e; mode = m; cond = c; offset = off; target = tgt; call = cl;
    @(posedge clk);
    #1;
    sb.push_back('{name, xpc, xlink, xf});
  endtask

  initial begin
    //   name          rst en mode         c  offset   target   call  pc       link     EFOU
    step("reset",      1, 1, MODE_INC,    0, 16'h0,    16'h0,    0, 16'h0000, 16'h0000, 4'b1000);
    step("inc1",       0, 1, MODE_INC,    0, 16'h0,    16'h0,    0, 16'h0001, 16'h0000, 4'b1000);
    step("inc2",       0, 1, MODE_INC,    1, 16'h5,    16'h77,   1, 16'h0002, 16'h0000, 4'b1000);
    step("inc3",       0, 1, MODE_INC,    0, 16'h0,    16'h0,    0, 16'h0003, 16'h0000, 4'b1000);
    step("rst_jump",   1, 1, MODE_JUMP,   0, 16'h0,    16'h0100, 1, 16'h0000, 16'h0000, 4'b1000);
    step("goto10",     0, 1, MODE_JUMP,   0, 16'h0,    16'h0010, 0, 16'h0010, 16'h0000, 4'b1000);
    step("br_taken",   0, 1, MODE_BRANCH, 1, 16'hFFFC, 16'h0,    0, 16'h000D, 16'h0000, 4'b1000);
    step("goto10b",    0, 1, MODE_JUMP,   0, 16'h0,    16'h0010, 0, 16'h0010, 16'h0000, 4'b1000);
    step("br_not",     0, 1, MODE_BRANCH, 0, 16'hFFFC, 16'h0,    1, 16'h0011, 16'h0000, 4'b1000);
    step("gotoFFFE",   0, 1, MODE_JUMP,   0, 16'h0,    16'hFFFE, 0, 16'hFFFE, 16'h0000, 4'b1000);
    step("br_wrap",    0, 1, MODE_BRANCH, 1, 16'h0003, 16'h0,    0, 16'h0002, 16'h0000, 4'b1000);
    step("gotoFFFF",   0, 1, MODE_JUMP,   0, 16'h0,    16'hFFFF, 0, 16'hFFFF, 16'h0000, 4'b1000);
    step("inc_wrap",   0, 1, MODE_INC,    0, 16'h0,    16'h0,    0, 16'h0000, 16'h0000, 4'b1000);
    step("goto20",     0, 1, MODE_JUMP,   0, 16'h0,    16'h0020, 0, 16'h0020, 16'h0000, 4'b1000);
    step("call100",    0, 1, MODE_JUMP,   0, 16'h0,    16'h0100, 1, 16'h0100, 16'h0021, 4'b0000);
    step("ret1",       0, 1, MODE_RET,    0, 16'h0,    16'h0,    0, 16'h0021, 16'h0000, 4'b1000);
    // Five nested calls into a four-entry stack.
    step("goto10c",    0, 1, MODE_JUMP,   0, 16'h0,    16'h0010, 0, 16'h0010, 16'h0000, 4'b1000);
    step("callA",      0, 1, MODE_JUMP,   0, 16'h0,    16'h0020, 1, 16'h0020, 16'h0011, 4'b0000);
    step("callB",      0, 1, MODE_JUMP,   0, 16'h0,    16'h0030, 1, 16'h0030, 16'h0021, 4'b0000);
    step("callC",      0, 1, MODE_JUMP,   0, 16'h0,    16'h0040, 1, 16'h0040, 16'h0031, 4'b0000);
    step("callD",      0, 1, MODE_JUMP,   0, 16'h0,    16'h0050, 1, 16'h0050, 16'h0041, 4'b0100);
    step("callE_ovf",  0, 1, MODE_JUMP,   0, 16'h0,    16'h0300, 1, 16'h0300, 16'h0051, 4'b0110);
    step("retA",       0, 1, MODE_RET,    1, 16'h9,    16'h9,    1, 16'h0051, 16'h0041, 4'b0010);
    step("retB",       0, 1, MODE_RET,    0, 16'h0,    16'h0,    0, 16'h0041, 16'h0031, 4'b0010);
    step("retC",       0, 1, MODE_RET,    0, 16'h0,    16'h0,    0, 16'h0031, 16'h0021, 4'b0010);
    step("retD",       0, 1, MODE_RET,    0, 16'h0,    16'h0,    0, 16'h0021, 16'h0000, 4'b1010);
    step("ret_unf",    0, 1, MODE_RET,    0, 16'h0,    16'h0,    0, 16'h0022, 16'h0000, 4'b1011);
    // Stall with a pending call-jump, then release it.
    step("call80",     0, 1, MODE_JUMP,   0, 16'h0,    16'h0080, 1, 16'h0080, 16'h0023, 4'b0011);
    step("stall1",     0, 0, MODE_JUMP,   0, 16'h0,    16'h0200, 1, 16'h0080, 16'h0023, 4'b0011);
    step("stall2",     0, 0, MODE_JUMP,   0, 16'h0,    16'h0200, 1, 16'h0080, 16'h0023, 4'b0011);
    step("stall3",     0, 0, MODE_JUMP,   0, 16'h0,    16'h0200, 1, 16'h0080, 16'h0023, 4'b0011);
    step("unstall",    0, 1, MODE_JUMP,   0, 16'h0,    16'h0200, 1, 16'h0200, 16'h0081, 4'b0011);
    step("stall_ret",  0, 0, MODE_RET,    0, 16'h0,    16'h0,    0, 16'h0200, 16'h0081, 4'b0011);
    step("ret_81",     0, 1, MODE_RET,    0, 16'h0,    16'h0,    0, 16'h0081, 16'h0023, 4'b0011);
    step("ret_23",     0, 1, MODE_RET,    0, 16'h0,    16'h0,    0, 16'h0023, 16'h0000, 4'b1011);
    step("call_pre",   0, 1, MODE_JUMP,   0, 16'h0,    16'h0400, 1, 16'h0400, 16'h0024, 4'b0011);
    step("rst_stall",  1, 0, MODE_RET,    0, 16'h0,    16'h0,    0, 16'h0000, 16'h0000, 4'b1000);

    // Bounded drain of the scoreboard before the summary.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
